pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of the datapath payload (pc, operands, immediate, register fields concatenated).
REQ-002 Parameter CTRL_W, default 16: width of the control bundle (reg_write, mem_to_reg, alu_op, halted, ...).
REQ-003 Parameter BUBBLE_CTRL, default all-zero: control value presented whenever the stage holds no valid instruction.
REQ-004 Parameter SKID, default 0: 0 = single-entry stage; 1 = two-entry stage with registered in_ready.
REQ-005 Parameter CNT_W, default 16: width of the stall counter.
REQ-006 One clock; reset is asynchronous and active-high. Ports: clk, rst.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 in_valid  in  1  upstream stage presents an instruction.
REQ-010 in_ctrl  in  CTRL_W  upstream control bundle.
REQ-011 in_data  in  DATA_W  upstream payload.
REQ-012 in_ready  out  1  stage accepts this cycle.
REQ-013 flush  in  1  squash all held instructions (branch/jump taken).
REQ-014 out_valid  out  1  stage output holds a valid instruction.
REQ-015 out_ctrl  out  CTRL_W  registered control bundle; BUBBLE_CTRL when out_valid=0.
REQ-016 out_data  out  DATA_W  registered payload.
REQ-017 out_ready  in  1  downstream consumes this cycle.
REQ-018 stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-019 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; both take effect on the same rising edge.
REQ-020 SKID=0: in_ready = out_ready | ~out_valid (combinational); latency in_valid->out_valid is exactly 1 cycle.
REQ-021 SKID=0: on transfer in, out_ctrl/out_data load in_ctrl/in_data; on transfer out without transfer in, out_valid clears and out_ctrl loads BUBBLE_CTRL; otherwise all outputs hold.
REQ-022 SKID=1: storage is a main entry driving the outputs plus one skid entry; in_ready is a flop equal to "skid entry empty"; no combinational path from out_ready to in_ready.
REQ-023 SKID=1 states: EMPTY (0 held), ONE (main valid), TWO (main+skid valid).
REQ-024 SKID=1 transitions: EMPTY-in->ONE; ONE-in&~out->TWO (input captured into skid); ONE-in&out->ONE (main reloads); ONE-out&~in->EMPTY; TWO-out->ONE (skid moves to main); TWO never accepts.
REQ-025 Ordering is strictly FIFO; no instruction is duplicated or dropped except by flush.
REQ-026 flush has priority over every transfer: next cycle all entries are empty, out_valid=0, out_ctrl=BUBBLE_CTRL, and an instruction offered in the flush cycle is discarded.
REQ-027 out_data is don't-care while out_valid=0 but does not toggle without a load.
REQ-028 stall_cnt increments by 1 each cycle with out_valid & ~out_ready, saturates at all-ones, and never wraps; flush does not clear it.

Reset
REQ-029 While rst=1: out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, stall_cnt=0, skid entry empty; in_ready=1 for SKID=1 and follows REQ-020 for SKID=0.
REQ-030 Reset asserted mid-transfer discards all held instructions; the first accept is possible on the first rising edge after rst deasserts.

Structure
REQ-031 A shared package pipe_pkg holds the default widths, the BUBBLE_CTRL default and the SKID-state enum (EMPTY/ONE/TWO).
REQ-032 The two-entry storage and its state machine sit in sub-module pipe_skid_buf, instantiated only when SKID=1.

Verification
REQ-033 Reset: assert rst with in_valid=1 -> out_valid=0, out_ctrl=BUBBLE_CTRL, stall_cnt=0; first instruction appears 1 cycle after the first accept.
REQ-034 Streaming, SKID=0, out_ready=1: 8 instructions data 0x10..0x17 back-to-back -> outputs 0x10..0x17 on consecutive cycles, 1-cycle latency.
REQ-035 Backpressure, SKID=1: out_ready=0 for 3 cycles while offering 0xA0, 0xA1, 0xA2 -> in_ready falls after 0xA1 is captured, 0xA2 is held upstream, stall_cnt=3, order A0,A1,A2 is preserved after release.
REQ-036 Flush concurrent with an accept in state TWO -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, the offered instruction never appears, in_ready=1.
REQ-037 Saturation, CNT_W=4: hold stall for 20 cycles -> stall_cnt stops at 15.
REQ-038 Random valid/ready/flush, 10k cycles, both SKID values -> scoreboard matches FIFO order excluding flushed entries.

Source files
------------

// File: rtl/pipe_pkg.sv
// Purpose : shared widths, bubble control default and skid-buffer state encoding
// Latency : n/a (declarations only)
// Backpr. : n/a
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 16;
  localparam int DEF_CNT_W  = 16;

  // Control value shown while the stage holds no instruction (a NOP bundle).
  localparam logic [DEF_CTRL_W-1:0] DEF_BUBBLE_CTRL = '0;

  // Occupancy of the two-entry stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Purpose : two-entry pipeline stage (main entry drives outputs, skid entry catches one extra)
// Latency : 1 cycle in_valid -> out_valid
// Backpr. : in_ready is a flop (= skid entry empty); no comb path out_ready -> in_ready
// Ports   : clk/rst; in_valid/in_ctrl/in_data/in_ready upstream; flush squash;
//           out_valid/out_ctrl/out_data/out_ready downstream
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = DEF_DATA_W,
  parameter int                 CTRL_W      = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = CTRL_W'(DEF_BUBBLE_CTRL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  skid_state_t       r_state;
  skid_state_t       w_state_nxt;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_in_rdy;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;
  logic w_clr_main;

  assign w_in_xfer  = in_valid & r_in_rdy;
  assign w_out_xfer = (r_state != EMPTY) & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    w_clr_main     = 1'b0;
    if (flush) begin
      // Squash everything, including whatever is offered this cycle.
      w_state_nxt = EMPTY;
      w_clr_main  = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt  = ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_ld_main_in = 1'b1;
          end else if (w_in_xfer) begin
            w_state_nxt = TWO;
            w_ld_skid   = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = EMPTY;
            w_clr_main  = 1'b1;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (w_out_xfer) begin
            w_state_nxt    = ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_clr_main  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_in_rdy    <= 1'b1;
      r_main_ctrl <= BUBBLE_CTRL;
      r_main_data <= '0;
      r_skid_ctrl <= BUBBLE_CTRL;
      r_skid_data <= '0;
    end else begin
      r_state  <= w_state_nxt;
      // Ready for next cycle is decided from the next occupancy, so it stays a flop.
      r_in_rdy <= (w_state_nxt != TWO);
      if (w_ld_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_ld_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end else if (w_clr_main) begin
        r_main_ctrl <= BUBBLE_CTRL;
      end
      if (w_ld_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  assign in_ready  = r_in_rdy;
  assign out_valid = (r_state != EMPTY);
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Purpose : pipeline stage register with bubble insertion, flush and stall counter
// Latency : 1 cycle in_valid -> out_valid (both SKID settings)
// Backpr. : SKID=0 in_ready = out_ready | ~out_valid (comb); SKID=1 registered in_ready
// Ports   : clk/rst; in_* upstream handshake + payload; flush; out_* downstream;
//           stall_cnt saturating count of out_valid & ~out_ready cycles
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = DEF_DATA_W,
  parameter int                 CTRL_W      = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = CTRL_W'(DEF_BUBBLE_CTRL),
  parameter int                 SKID        = 0,
  parameter int                 CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              w_in_ready;
  logic              w_out_valid;
  logic [CTRL_W-1:0] w_out_ctrl;
  logic [DATA_W-1:0] w_out_data;
  logic [CNT_W-1:0]  r_stall;

  if (SKID != 0) begin : g_skid
    pipe_skid_buf #(
      .DATA_W      (DATA_W),
      .CTRL_W      (CTRL_W),
      .BUBBLE_CTRL (BUBBLE_CTRL)
    ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .in_ready  (w_in_ready),
      .flush     (flush),
      .out_valid (w_out_valid),
      .out_ctrl  (w_out_ctrl),
      .out_data  (w_out_data),
      .out_ready (out_ready)
    );
  end else begin : g_single
    logic              r_vld;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_ready = out_ready | ~r_vld;
    assign w_in_xfer  = in_valid & w_in_ready;
    assign w_out_xfer = r_vld & out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_ctrl <= BUBBLE_CTRL;
        r_data <= '0;
      end else if (flush) begin
        // Data is left alone so it only changes on a real load.
        r_vld  <= 1'b0;
        r_ctrl <= BUBBLE_CTRL;
      end else if (w_in_xfer) begin
        r_vld  <= 1'b1;
        r_ctrl <= in_ctrl;
        r_data <= in_data;
      end else if (w_out_xfer) begin
        r_vld  <= 1'b0;
        r_ctrl <= BUBBLE_CTRL;
      end
    end

    assign w_out_valid = r_vld;
    assign w_out_ctrl  = r_ctrl;
    assign w_out_data  = r_data;
  end

  // Saturating stall counter; deliberately untouched by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_out_valid && !out_ready && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_ctrl  = w_out_ctrl;
  assign out_data  = w_out_data;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose : directed + random checks of pipe_stage_reg, SKID=0 (CNT_W=4) and SKID=1
// Latency : n/a
// Backpr. : n/a
module tb_pipe_stage_reg;

  localparam logic [15:0] BUB0 = 16'h00BB;
  localparam logic [15:0] BUB1 = 16'hB0B0;

  logic        clk;
  logic        rst;
  logic        v    [2];
  logic [15:0] c    [2];
  logic [31:0] d    [2];
  logic        ordy [2];
  logic        fl   [2];
  logic        irdy [2];
  logic        ovld [2];
  logic [15:0] octl [2];
  logic [31:0] odat [2];
  logic [3:0]  scnt0;
  logic [15:0] scnt1;

  int n_chk;
  int n_fail;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .BUBBLE_CTRL(BUB0), .SKID(0), .CNT_W(4)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(v[0]), .in_ctrl(c[0]), .in_data(d[0]), .in_ready(irdy[0]),
    .flush(fl[0]), .out_valid(ovld[0]), .out_ctrl(octl[0]), .out_data(odat[0]),
    .out_ready(ordy[0]), .stall_cnt(scnt0));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .BUBBLE_CTRL(BUB1), .SKID(1), .CNT_W(16)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(v[1]), .in_ctrl(c[1]), .in_data(d[1]), .in_ready(irdy[1]),
    .flush(fl[1]), .out_valid(ovld[1]), .out_ctrl(octl[1]), .out_data(odat[1]),
    .out_ready(ordy[1]), .stall_cnt(scnt1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ctl_of(input logic [31:0] dd);
    return dd[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] bub(input int k);
    return (k == 0) ? BUB0 : BUB1;
  endfunction

  task automatic offer(input int k, input logic vv, input logic [31:0] dd);
    v[k] = vv;
    d[k] = dd;
    c[k] = ctl_of(dd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      offer(k, 1'b0, 32'h0);
      ordy[k] = 1'b1;
      fl[k]   = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  int          cnt_m [2];
  int          head  [2];
  logic [31:0] sb    [2][4];
  logic        exp_rdy;
  logic        pop;
  logic        push;

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // ---- reset with an instruction offered ----
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      offer(k, 1'b1, 32'h55);
      ordy[k] = 1'b1;
      fl[k]   = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", ovld[k], 1'b0);
      chk("rst_out_ctrl", octl[k], bub(k));
      chk("rst_out_data", odat[k], 32'h0);
      chk("rst_in_ready", irdy[k], 1'b1);
    end
    chk("rst_stall0", scnt0, 4'd0);
    chk("rst_stall1", scnt1, 16'd0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("first_valid", ovld[k], 1'b1);
      chk("first_data", odat[k], 32'h55);
      chk("first_ctrl", octl[k], ctl_of(32'h55));
      offer(k, 1'b0, 32'h0);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("drain_valid", ovld[k], 1'b0);
      chk("drain_ctrl", octl[k], bub(k));
    end

    // ---- streaming 0x10..0x17, out_ready=1 ----
    do_reset();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 2; k++) offer(k, 1'b1, 32'h10 + i);
      tick();
      for (int k = 0; k < 2; k++) begin
        chk("stream_valid", ovld[k], 1'b1);
        chk("stream_data", odat[k], 32'h10 + i);
      end
    end
    for (int k = 0; k < 2; k++) offer(k, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 2; k++) chk("stream_end", ovld[k], 1'b0);

    // ---- backpressure on SKID=1 ----
    do_reset();
    ordy[1] = 1'b0;
    offer(1, 1'b1, 32'hA0);
    tick();
    chk("bp_rdy_after_a0", irdy[1], 1'b1);
    offer(1, 1'b1, 32'hA1);
    tick();
    chk("bp_rdy_after_a1", irdy[1], 1'b0);
    offer(1, 1'b1, 32'hA2);
    tick();
    chk("bp_rdy_hold", irdy[1], 1'b0);
    tick();
    chk("bp_stall_cnt", scnt1, 16'd3);
    chk("bp_head_a0", odat[1], 32'hA0);
    ordy[1] = 1'b1;
    tick();
    chk("bp_head_a1", odat[1], 32'hA1);
    chk("bp_ctrl_a1", octl[1], ctl_of(32'hA1));
    chk("bp_rdy_back", irdy[1], 1'b1);
    tick();
    chk("bp_head_a2", odat[1], 32'hA2);
    chk("bp_valid_a2", ovld[1], 1'b1);
    offer(1, 1'b0, 32'h0);
    tick();
    chk("bp_empty", ovld[1], 1'b0);
    chk("bp_stall_kept", scnt1, 16'd3);

    // ---- flush: SKID=1 in TWO, SKID=0 concurrent with an accept ----
    do_reset();
    ordy[1] = 1'b0;
    offer(0, 1'b1, 32'hE0);
    offer(1, 1'b1, 32'hB0);
    tick();
    offer(0, 1'b1, 32'hE1);
    offer(1, 1'b1, 32'hB1);
    fl[0] = 1'b1;
    tick();
    chk("fl0_valid", ovld[0], 1'b0);
    chk("fl0_ctrl", octl[0], BUB0);
    chk("fl0_data_hold", odat[0], 32'hE0);
    fl[0] = 1'b0;
    offer(0, 1'b0, 32'h0);
    chk("fl_two_rdy", irdy[1], 1'b0);
    offer(1, 1'b1, 32'hB2);
    fl[1] = 1'b1;
    tick();
    chk("fl1_valid", ovld[1], 1'b0);
    chk("fl1_ctrl", octl[1], BUB1);
    chk("fl1_rdy", irdy[1], 1'b1);
    chk("fl1_stall_kept", scnt1, 16'd2);
    fl[1] = 1'b0;
    offer(1, 1'b0, 32'h0);
    ordy[1] = 1'b1;
    tick();
    tick();
    chk("fl0_stays_empty", ovld[0], 1'b0);
    chk("fl1_stays_empty", ovld[1], 1'b0);

    // ---- stall counter saturation, CNT_W=4 ----
    do_reset();
    ordy[0] = 1'b0;
    offer(0, 1'b1, 32'hC0);
    tick();
    offer(0, 1'b0, 32'h0);
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", scnt0, 4'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_15", scnt0, 4'd15);
    chk("sat_data_hold", odat[0], 32'hC0);

    // ---- random valid/ready/flush with FIFO scoreboard ----
    do_reset();
    for (int k = 0; k < 2; k++) begin
      cnt_m[k] = 0;
      head[k]  = 0;
    end
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 2; k++) begin
        offer(k, 1'($urandom_range(0, 1)), $urandom);
        ordy[k] = ($urandom_range(0, 3) != 0);
        fl[k]   = ($urandom_range(0, 19) == 0);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        exp_rdy = (k == 0) ? (ordy[k] || (cnt_m[k] == 0)) : (cnt_m[k] < 2);
        chk("rnd_in_ready", irdy[k], exp_rdy);
        chk("rnd_out_valid", ovld[k], cnt_m[k] != 0);
        if (cnt_m[k] == 0) chk("rnd_bubble", octl[k], bub(k));
        if (fl[k]) begin
          cnt_m[k] = 0;
        end else begin
          pop  = (cnt_m[k] != 0) && ordy[k];
          push = v[k] && exp_rdy;
          if (pop) begin
            chk("rnd_data", odat[k], sb[k][head[k]]);
            chk("rnd_ctrl", octl[k], ctl_of(sb[k][head[k]]));
            head[k]  = (head[k] + 1) % 4;
            cnt_m[k] = cnt_m[k] - 1;
          end
          if (push) begin
            sb[k][(head[k] + cnt_m[k]) % 4] = d[k];
            cnt_m[k] = cnt_m[k] + 1;
          end
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
